// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port and a
// per-register pending scoreboard. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rs,
    input  logic [ADDR_W-1:0]   rt,
    output logic [DATA_W-1:0]   read1,
    output logic [DATA_W-1:0]   read2,
    input  logic                we,
    input  logic [ADDR_W-1:0]   rd,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [DATA_W-1:0]   stored1;
    logic [DATA_W-1:0]   stored2;
    logic                pend1;
    logic                pend2;
    logic                bypass_rs;
    logic                bypass_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (we && rd == ADDR_W'(i)) begin
                    regs[i] <= wr_data;
                end
            end
            pend_q <= pend_nxt;
        end
    end

    // Reservation is applied after the clear so a new producer wins.
    always_comb begin
        pend_nxt = pend_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (we && rd == ADDR_W'(i)) begin
                pend_nxt[i] = 1'b0;
            end
            if (rsv_en && rsv_addr == ADDR_W'(i)) begin
                pend_nxt[i] = 1'b1;
            end
        end
        pend_nxt[0] = 1'b0;
    end

    // Register 0 and unimplemented addresses fall through to zero.
    always_comb begin
        stored1 = '0;
        stored2 = '0;
        pend1   = 1'b0;
        pend2   = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs == ADDR_W'(i)) begin
                stored1 = regs[i];
                pend1   = pend_q[i];
            end
            if (rt == ADDR_W'(i)) begin
                stored2 = regs[i];
                pend2   = pend_q[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    localparam logic [ADDR_W:0] NREGS = NUM_REGS[ADDR_W:0];

    logic rd_ok;

    assign rd_ok     = we && (rd != '0) && ({1'b0, rd} < NREGS);
    assign bypass_rs = rd_ok && (rd == rs);
    assign bypass_rt = rd_ok && (rd == rt);
    assign read1     = bypass_rs ? wr_data : stored1;
    assign read2     = bypass_rt ? wr_data : stored2;
`else
    assign bypass_rs = 1'b0;
    assign bypass_rt = 1'b0;
    assign read1     = stored1;
    assign read2     = stored2;
`endif

    assign stall   = (pend1 & ~bypass_rs) | (pend2 & ~bypass_rt);
    assign pending = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed steps then random traffic against an
// array-based reference model.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs, rt, rd, rsv_addr;
    logic          we, rsv_en;
    logic [DW-1:0] wr_data, read1, read2;
    logic          stall;
    logic [NR-1:0] pending;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_regs [32];
    logic [31:0]   m_pend;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt),
        .read1(read1), .read2(read2), .we(we), .rd(rd),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .stall(stall), .pending(pending)
    );

    function automatic bit legal(input logic [AW-1:0] a);
        return (a != 0) && (int'(a) < NR);
    endfunction

    function automatic bit byp(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        return we && legal(rd) && (rd == a);
`else
        return (a != a);
`endif
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!legal(a)) return '0;
        if (byp(a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        return (legal(rs) && m_pend[rs] && !byp(rs)) ||
               (legal(rt) && m_pend[rt] && !byp(rt));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":read1"}, read1, exp_rd(rs));
        chk({tag, ":read2"}, read2, exp_rd(rt));
        chk({tag, ":stall"}, {31'b0, stall}, {31'b0, exp_stall()});
        chk({tag, ":pending"}, {16'b0, pending}, m_pend);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pend = '0;
    endtask

    task automatic idle();
        we = 0; rsv_en = 0;
    endtask

    // Check combinational outputs, clock once, advance the model.
    task automatic tick(input string tag);
        #1 check_all(tag);
        @(posedge clk);
        if (we && legal(rd)) begin
            m_regs[rd] = wr_data;
            m_pend[rd] = 1'b0;
        end
        if (rsv_en && legal(rsv_addr)) m_pend[rsv_addr] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; idle(); rs = 0; rt = 0; rd = 0; rsv_addr = 0; wr_data = 0;
        model_reset();
        #1 check_all("reset");
        @(negedge clk); rst_n = 1;

        // asynchronous reset mid-cycle
        we = 1; rd = 5; wr_data = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 6;
        tick("w5");
        idle(); rs = 5;
        #1 chk("pre_rst_read1", read1, 32'hDEADBEEF);
        #2 rst_n = 0;
        model_reset();
        #1 chk("rst_read1", read1, 32'h0);
        chk("rst_pending", {16'b0, pending}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        @(negedge clk); rst_n = 1;

        // basic write/read and reg 0
        we = 1; rd = 7; wr_data = 32'h12345678; rs = 7;
        tick("w7");
        idle();
        #1 chk("r7", read1, 32'h12345678);
        tick("r7");
        we = 1; rd = 0; wr_data = 32'hFFFFFFFF;
        tick("w0");
        idle(); rs = 0;
        #1 chk("r0", read1, 32'h0);
        tick("r0");

        // scoreboard set then clear
        rsv_en = 1; rsv_addr = 3;
        tick("rsv3");
        idle(); rs = 3;
        #1 chk("stall3", {31'b0, stall}, 32'h1);
        chk("pend3", {31'b0, pending[3]}, 32'h1);
        tick("hold3");
        we = 1; rd = 3; wr_data = 32'hA5;
        tick("wb3");
        idle();
        #1 chk("pend3_clr", {31'b0, pending[3]}, 32'h0);
        chk("stall3_clr", {31'b0, stall}, 32'h0);
        tick("after3");

        // simultaneous set/clear
        rsv_en = 1; rsv_addr = 4;
        tick("rsv4");
        we = 1; rd = 4; wr_data = 32'h77; rsv_en = 1; rsv_addr = 4;
        tick("setclr4");
        idle(); rs = 4;
        #1 chk("r4", read1, 32'h77);
        chk("pend4", {31'b0, pending[4]}, 32'h1);
        tick("after4");

        // write to pending operand in the same cycle
        rsv_en = 1; rsv_addr = 9;
        tick("rsv9");
        idle(); we = 1; rd = 9; wr_data = 32'h55AA; rs = 9;
`ifdef REGFILE_BYPASS_EN
        #1 chk("byp_read1", read1, 32'h55AA);
        chk("byp_stall", {31'b0, stall}, 32'h0);
`else
        #1 chk("nobyp_read1", read1, 32'h0);
        chk("nobyp_stall", {31'b0, stall}, 32'h1);
`endif
        tick("w9");
        idle();
        #1 chk("r9", read1, 32'h55AA);
        chk("stall9", {31'b0, stall}, 32'h0);
        tick("after9");

        // out-of-range addresses
        we = 1; rd = 20; wr_data = 32'hCAFE; rsv_en = 1; rsv_addr = 20;
        rs = 20; rt = 20;
        tick("oor_w");
        idle();
        #1 chk("oor_read1", read1, 32'h0);
        chk("oor_stall", {31'b0, stall}, 32'h0);
        tick("oor_r");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 0;
                model_reset();
                #1 check_all("rnd_rst");
                @(negedge clk); rst_n = 1;
            end
            rs       = AW'($urandom_range(0, 19));
            rt       = AW'($urandom_range(0, 19));
            rd       = AW'($urandom_range(0, 19));
            rsv_addr = AW'($urandom_range(0, 19));
            we       = 1'($urandom_range(0, 1));
            rsv_en   = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
